array_arbiter: RTL and testbench

Two-requester controller that shares one 8-entry `array` instance, with an optional clear sequencer. It sits between two client blocks and the array. It owns the array's `write`/`index`/`datain` pins and returns read data, done and error status per requester. Arbitration is round-robin, at most one array access per two cycles.

---
 rtl/array_arb_pkg.sv | 24 ++
 rtl/array_arbiter_if.sv | 30 +++
 rtl/array.sv | 28 ++
 rtl/array_arbiter_rr_pick.sv | 21 ++
 rtl/array_arbiter.sv | 131 +++++++++++++
 tb/tb_array_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/array_arb_pkg.sv
// Shared types and constants for the two-requester array arbiter.
// The clear sequencer is compiled only when ARRAY_ARB_CLEAR_EN is defined.
package array_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        CLEAR
    } arb_state_t;

    localparam int NUM_REQ  = 2;
    localparam int DEPTH    = 8;
    localparam int IDX_W    = 8;
    localparam int CLR_LAST = 7;

    function automatic logic in_range(input logic [IDX_W-1:0] i);
        return i < IDX_W'(DEPTH);
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic w);
        return {w, ~w};
    endfunction

endpackage

// File: rtl/array_arbiter_if.sv
// Client-side bundle of the array arbiter: per-requester request,
// completion and status, plus the clear request and busy flag.
interface array_arbiter_if
    import array_arb_pkg::*;
#(
    parameter int width = 32
);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            we;
    logic [NUM_REQ-1:0][IDX_W-1:0] idx;
    logic [NUM_REQ-1:0][width-1:0] wdata;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            done;
    logic [NUM_REQ-1:0]            err;
    logic [width-1:0]              rdata;
    logic                          clear;
    logic                          busy;

    modport slave (
        input  req, we, idx, wdata, clear,
        output gnt, done, err, rdata, busy
    );

    modport master (
        output req, we, idx, wdata, clear,
        input  gnt, done, err, rdata, busy
    );

endinterface

// File: rtl/array.sv
// 8-entry register array with synchronous write and combinational read.
// Indices outside the array read as zero and never write.
module array
    import array_arb_pkg::*;
#(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             write,
    input  logic [IDX_W-1:0] index,
    input  logic [width-1:0] datain,
    output logic [width-1:0] dataout
);

    logic [width-1:0] mem [DEPTH];
    logic             ok;

    assign ok = in_range(index);

    always_ff @(posedge clk) begin
        if (write && ok) begin
            mem[index[2:0]] <= datain;
        end
    end

    assign dataout = ok ? mem[index[2:0]] : '0;

endmodule

// File: rtl/array_arbiter_rr_pick.sv
// Combinational two-way round-robin selector; the pointer
// register lives in the arbiter.
module rr_pick (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       win,
    output logic       any
);

    assign any = |req;

    always_comb begin
        win = 1'b0;
        unique case (req)
            2'b11:   win = ptr;
            2'b10:   win = 1'b1;
            default: win = 1'b0;
        endcase
    end

endmodule

// File: rtl/array_arbiter.sv
// Round-robin arbiter sharing one array between two requesters.
// Optional clear sequencer enabled by ARRAY_ARB_CLEAR_EN.
module array_arbiter
    import array_arb_pkg::*;
#(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst,
    array_arbiter_if.slave   bus,
    output logic             arr_write,
    output logic [IDX_W-1:0] arr_index,
    output logic [width-1:0] arr_datain,
    input  logic [width-1:0] arr_dataout
);

    arb_state_t         state;
    logic               ptr;
    logic               win;
    logic               any;
    logic               l_win;
    logic               l_we;
    logic               l_ok;
    logic [NUM_REQ-1:0] gnt_q;
    logic [NUM_REQ-1:0] done_q;
    logic [NUM_REQ-1:0] err_q;
    logic [width-1:0]   rdata_q;

`ifdef ARRAY_ARB_CLEAR_EN
    logic busy_q;
    logic clr_pend;
    assign bus.busy = busy_q;
`else
    assign bus.busy = 1'b0;
`endif

    rr_pick u_pick (
        .req (bus.req),
        .ptr (ptr),
        .win (win),
        .any (any)
    );

    assign bus.gnt   = gnt_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= 1'b0;
            l_win      <= 1'b0;
            l_we       <= 1'b0;
            l_ok       <= 1'b0;
            gnt_q      <= '0;
            done_q     <= '0;
            err_q      <= '0;
            rdata_q    <= '0;
            arr_write  <= 1'b0;
            arr_index  <= '0;
            arr_datain <= '0;
`ifdef ARRAY_ARB_CLEAR_EN
            busy_q     <= 1'b0;
            clr_pend   <= 1'b0;
`endif
        end else begin
            gnt_q  <= '0;
            done_q <= '0;
            err_q  <= '0;
            unique case (state)
                IDLE: begin
`ifdef ARRAY_ARB_CLEAR_EN
                    // A waiting clear beats any request.
                    if (bus.clear || clr_pend) begin
                        state      <= CLEAR;
                        clr_pend   <= 1'b0;
                        busy_q     <= 1'b1;
                        arr_write  <= 1'b1;
                        arr_index  <= '0;
                        arr_datain <= '0;
                    end else
`endif
                    if (any) begin
                        state      <= ACCESS;
                        ptr        <= ~win;
                        l_win      <= win;
                        l_we       <= bus.we[win];
                        l_ok       <= in_range(bus.idx[win]);
                        gnt_q      <= onehot(win);
                        arr_index  <= bus.idx[win];
                        arr_datain <= bus.wdata[win];
                        arr_write  <= bus.we[win]
                                    & in_range(bus.idx[win]);
                    end
                end
                ACCESS: begin
                    state      <= IDLE;
                    done_q     <= onehot(l_win);
                    err_q      <= l_ok ? '0 : onehot(l_win);
                    rdata_q    <= (!l_we && l_ok) ? arr_dataout : '0;
                    arr_write  <= 1'b0;
                    arr_index  <= '0;
                    arr_datain <= '0;
`ifdef ARRAY_ARB_CLEAR_EN
                    if (bus.clear) begin
                        clr_pend <= 1'b1;
                    end
`endif
                end
`ifdef ARRAY_ARB_CLEAR_EN
                CLEAR: begin
                    // arr_index doubles as the sweep counter.
                    if (arr_index == IDX_W'(CLR_LAST)) begin
                        state     <= IDLE;
                        busy_q    <= 1'b0;
                        arr_write <= 1'b0;
                        arr_index <= '0;
                    end else begin
                        arr_index <= arr_index + IDX_W'(1);
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_array_arbiter.sv
// Scoreboard bench for array_arbiter wired to a real array.
// Covers both ARRAY_ARB_CLEAR_EN builds.
module tb_array_arbiter;
    import array_arb_pkg::*;

    typedef struct {
        logic [1:0]  done;
        logic [1:0]  err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        arr_write;
    logic [7:0]  arr_index;
    logic [31:0] arr_datain;
    logic [31:0] arr_dataout;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    logic rst_q = 1'b1;
    logic [1:0] prev_gnt = '0;
    logic no_wr = 1'b0;
    logic saw_wr = 1'b0;
    exp_t exp_q[$];
    exp_t e;

    array_arbiter_if #(.width(32)) bus ();

    array_arbiter #(.width(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .arr_write   (arr_write),
        .arr_index   (arr_index),
        .arr_datain  (arr_datain),
        .arr_dataout (arr_dataout)
    );

    array #(.width(32)) u_arr (
        .clk     (clk),
        .write   (arr_write),
        .index   (arr_index),
        .datain  (arr_datain),
        .dataout (arr_dataout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops an expectation for every done pulse.
    always @(negedge clk) begin
        if (!rst && !rst_q) begin
            if (bus.done != 0 || prev_gnt != 0)
                chk("done_follows_gnt", 64'(bus.done), 64'(prev_gnt));
            if (bus.done != 0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'(bus.done), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("done_vec", 64'(bus.done), 64'(e.done));
                    chk("err_vec", 64'(bus.err), 64'(e.err));
                    chk("rdata", 64'(bus.rdata), 64'(e.rdata));
                end
            end
        end
        if (no_wr && arr_write) saw_wr = 1'b1;
        prev_gnt = bus.gnt;
    end

    function automatic logic [1:0] oh(input int p);
        return (p == 0) ? 2'b01 : 2'b10;
    endfunction

    task automatic push(input int p, input logic er, input logic [31:0] rd);
        exp_t x;
        x.done  = oh(p);
        x.err   = er ? oh(p) : 2'b00;
        x.rdata = rd;
        exp_q.push_back(x);
    endtask

    task automatic wait_gnt(input int p, output int n);
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (bus.gnt[p]) break;
            n++;
        end
        if (n >= 20) chk("gnt_timeout", 64'(0), 64'(1));
    endtask

    task automatic drain();
        for (int k = 0; k < 10; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        chk("queue_drained", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
    endtask

    task automatic do_req(input int p, input logic w, input logic [7:0] ix,
                          input logic [31:0] wd, input logic er,
                          input logic [31:0] rd, input bit lat);
        int n;
        @(posedge clk);
        #1;
        bus.req[p]   = 1'b1;
        bus.we[p]    = w;
        bus.idx[p]   = ix;
        bus.wdata[p] = wd;
        push(p, er, rd);
        wait_gnt(p, n);
        if (lat) chk("gnt_latency", 64'(n), 64'(1));
        @(posedge clk);
        #1;
        bus.req[p] = 1'b0;
        drain();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_gnt"}, 64'(bus.gnt), 64'(0));
        chk({tag, "_done"}, 64'(bus.done), 64'(0));
        chk({tag, "_err"}, 64'(bus.err), 64'(0));
        chk({tag, "_rdata"}, 64'(bus.rdata), 64'(0));
        chk({tag, "_busy"}, 64'(bus.busy), 64'(0));
        chk({tag, "_arr_write"}, 64'(arr_write), 64'(0));
        chk({tag, "_arr_index"}, 64'(arr_index), 64'(0));
        chk({tag, "_arr_datain"}, 64'(arr_datain), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int last;
        int bsum;
        logic [31:0] exp0;
        bus.req   = '0;
        bus.we    = '0;
        bus.idx   = '0;
        bus.wdata = '0;
        bus.clear = 1'b0;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single write then read, plus setup of entries 0 and 1.
        do_req(0, 1'b1, 8'd3, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1);
        do_req(0, 1'b0, 8'd3, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1);
        do_req(0, 1'b1, 8'd0, 32'hA0A0A0A0, 1'b0, 32'h0, 1'b0);
        do_req(0, 1'b1, 8'd1, 32'h11111111, 1'b0, 32'h0, 1'b0);

        // Contention from a fresh pointer.
        apply_reset();
        @(posedge clk);
        #1;
        bus.we  = 2'b00;
        bus.idx = '0;
        for (int g = 0; g < 4; g++) push(g % 2, 1'b0, 32'hA0A0A0A0);
        bus.req = 2'b11;
        last = 0;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            while (n < 20) begin
                @(negedge clk);
                if (bus.gnt != 0) break;
                n++;
            end
            chk("rr_order", 64'(bus.gnt), 64'(oh(g % 2)));
            if (g > 0) chk("gnt_spacing", 64'(cyc - last), 64'(2));
            last = cyc;
        end
        @(posedge clk);
        #1;
        bus.req = 2'b00;
        drain();

        // Out-of-range write must not touch the array.
        no_wr = 1'b1;
        do_req(1, 1'b1, 8'h09, 32'h55, 1'b1, 32'h0, 1'b1);
        no_wr = 1'b0;
        chk("oor_no_write", 64'(saw_wr), 64'(0));
        do_req(1, 1'b0, 8'd1, 32'h0, 1'b0, 32'h11111111, 1'b1);

        for (int i = 0; i < 8; i++)
            do_req(i % 2, 1'b1, 8'(i), 32'(i + 1) * 32'h11, 1'b0, 32'h0, 1'b0);

`ifdef ARRAY_ARB_CLEAR_EN
        @(posedge clk);
        #1;
        bus.clear  = 1'b1;
        bus.req[0] = 1'b1;
        bus.we[0]  = 1'b0;
        bus.idx[0] = 8'd5;
        push(0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        bus.clear = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("clr_busy", 64'(bus.busy), 64'(1));
            chk("clr_index", 64'(arr_index), 64'(i));
            chk("clr_write", 64'(arr_write), 64'(1));
            chk("clr_datain", 64'(arr_datain), 64'(0));
        end
        wait_gnt(0, n);
        chk("clr_gnt_wait", 64'(n), 64'(1));
        chk("clr_busy_end", 64'(bus.busy), 64'(0));
        @(posedge clk);
        #1;
        bus.req[0] = 1'b0;
        drain();
        do_req(1, 1'b0, 8'd2, 32'h0, 1'b0, 32'h0, 1'b1);
        exp0 = 32'h0;
`else
        @(posedge clk);
        #1;
        bus.clear = 1'b1;
        @(posedge clk);
        #1;
        bus.clear = 1'b0;
        bsum = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bsum += int'(bus.busy) + int'(arr_write);
        end
        chk("noclr_busy", 64'(bsum), 64'(0));
        do_req(0, 1'b0, 8'd5, 32'h0, 1'b0, 32'h66, 1'b1);
        exp0 = 32'h11;
`endif

        // Reset in the ACCESS cycle of a read.
        @(posedge clk);
        #1;
        bus.req[0] = 1'b1;
        bus.we[0]  = 1'b0;
        bus.idx[0] = 8'd3;
        wait_gnt(0, n);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        bus.req = 2'b00;
        @(negedge clk);
        chk_zero("midrst");
        @(posedge clk);
        #1;
        bus.we  = 2'b00;
        bus.idx = '0;
        push(0, 1'b0, exp0);
        bus.req = 2'b11;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (bus.gnt != 0) break;
            n++;
        end
        chk("post_rst_first_gnt", 64'(bus.gnt), 64'(2'b01));
        @(posedge clk);
        #1;
        bus.req = 2'b00;
        drain();

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
